// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed multiply/divide engine. Once a request is accepted it runs
//   one shift-add (MULT) or restoring shift-subtract (DIV) iteration per clock on
//   the operand magnitudes. Signs are applied in a single fix-up cycle, and the
//   result is registered onto hi/lo in the final cycle together with a done pulse.
//   Timing: accept on edge 0, iterate on edges 1..WIDTH, sign fix on edge WIDTH+1,
//   and hi/lo/done are written on edge WIDTH+2.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low; clears all state
//   start     in   1      request, sampled only while idle
//   op        in   1      0 = MULT, 1 = DIV; sampled with start
//   a         in   WIDTH  multiplicand / dividend (signed)
//   b         in   WIDTH  multiplier / divisor (signed)
//   hi        out  WIDTH  MULT: upper product word; DIV: remainder
//   lo        out  WIDTH  MULT: lower product word; DIV: quotient
//   busy      out  1      operation in flight
//   done      out  1      one-cycle completion pulse
//   div_zero  out  1      one-cycle pulse for DIV by zero (coincides with done)

module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               op_r;
    logic               neg_r;      // result sign differs from a positive result
    logic               sign_a_r;   // remainder takes the dividend sign
    logic [WIDTH-1:0]   addend;     // |a| for MULT, |b| for DIV

    // MULT: {partial product, remaining multiplier bits}
    // DIV : {partial remainder, dividend bits still to shift in / quotient bits}
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The magnitude of the most negative value wraps back to itself,
    // which is the correct unsigned magnitude.
    assign mag_a = a[WIDTH-1] ? ('0 - a) : a;
    assign mag_b = b[WIDTH-1] ? ('0 - b) : b;

    // Shift-add: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    assign mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);

    // Restoring step: shift the next dividend bit into the partial remainder,
    // then keep the difference only if it did not go negative.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, addend};
    assign div_ge    = (div_trial >= {1'b0, addend});
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

    assign prod_fix = neg_r    ? ('0 - acc) : acc;
    assign quot_fix = neg_r    ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = sign_a_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            op_r     <= 1'b0;
            neg_r    <= 1'b0;
            sign_a_r <= 1'b0;
            addend   <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            // Divide by zero completes at once; hi/lo are left untouched.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            op_r     <= op;
                            neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_a_r <= a[WIDTH-1];
                            count    <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                            if (op) begin
                                acc    <= {{WIDTH{1'b0}}, mag_a};
                                addend <= mag_b;
                            end else begin
                                acc    <= {{WIDTH{1'b0}}, mag_b};
                                addend <= mag_a;
                            end
                        end
                    end
                end
                RUN: begin
                    if (op_r) begin
                        acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mult_sum, acc[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    acc   <= op_r ? {rem_fix, quot_fix} : prod_fix;
                    state <= DONE;
                end
                DONE: begin
                    hi    <= acc[2*WIDTH-1:WIDTH];
                    lo    <= acc[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit (WIDTH = 32): a vector table plus random
//   operations checked against an arithmetic model, followed by hand-written
//   sequences for back-to-back starts, hold behaviour, ignored starts and reset abort.
//   Expected results are pushed into a scoreboard when an operation starts and
//   are compared whenever the unit signals done.

module tb_mult_div_unit;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    vec_t         vecs[16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    // Issue one operation. With b2b set the start is driven immediately
    // (used right after a done edge, while done is still high).
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e, input bit b2b);
        int n;
        if (!b2b) @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (e.dz) begin
            chk("dz_done", 32'(done), 32'd1);
            chk("dz_busy", 32'(busy), 32'd0);
        end else begin
            chk("busy_after_start", 32'(busy), 32'd1);
            n = 0;
            while (n <= LAT + 8) begin
                @(posedge clk);
                #1;
                n++;
                if (done) break;
            end
            chk("latency", 32'(n), 32'(LAT));
            chk("busy_at_done", 32'(busy), 32'd0);
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        int          q;
        int          r;
        e.dz = 1'b0;
        if (!o) begin
            p    = 64'(longint'(int'(x)) * longint'(int'(y)));
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            q    = int'(x) / int'(y);
            r    = int'(x) % int'(y);
            e.hi = 32'(r);
            e.lo = 32'(q);
        end
        return e;
    endfunction

    initial begin
        exp_t         e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           cnt;

        //          op    a             b             hi            lo            dz
        vecs[0]  = '{1'b0, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0};
        vecs[1]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 32'h00000005, 32'h00000000, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h00000000, 32'h00003039, 32'h00000000, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[11] = '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[13] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0};
        vecs[15] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h0,        32'h0,        1'b1};

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Vector table; divide-by-zero rows expect hi/lo to keep the previous result.
        for (int i = 0; i < 16; i++) begin
            e.hi = vecs[i].dz ? last_hi : vecs[i].hi;
            e.lo = vecs[i].dz ? last_lo : vecs[i].lo;
            e.dz = vecs[i].dz;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b0);
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 200)) : $urandom;
            if (i % 2 == 1 && y == '0) y = 32'd3;
            if (i % 2 == 1 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
            if (i % 4 == 3) y = '0 - y;
            run_op(1'(i % 2), x, y, model(1'(i % 2), x, y), 1'b0);
        end

        // done is a single-cycle pulse and hi/lo hold while idle.
        e = model(1'b0, 32'h00000003, 32'hFFFFFFFC);
        run_op(1'b0, 32'h00000003, 32'hFFFFFFFC, e, 1'b0);
        @(posedge clk);
        #1;
        chk("done_single", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_hi", hi, 32'hFFFFFFFF);
        chk("hold_lo", lo, 32'hFFFFFFF4);

        // Start accepted in the cycle done is high, including a divide-by-zero.
        run_op(1'b0, 32'h00000005, 32'h00000006, model(1'b0, 32'd5, 32'd6), 1'b0);
        run_op(1'b1, 32'h00000064, 32'h00000007, model(1'b1, 32'd100, 32'd7), 1'b1);
        e.hi = 32'h00000002;
        e.lo = 32'h0000000E;
        e.dz = 1'b1;
        run_op(1'b1, 32'h00000009, 32'h00000000, e, 1'b1);
        @(posedge clk);
        #1;
        chk("dz_single", 32'(div_zero), 32'd0);

        // Start while busy is ignored; reset mid-operation aborts with no done.
        @(negedge clk);
        op    = 1'b0;
        a     = 32'h00000003;
        b     = 32'hFFFFFFFC;
        start = 1'b1;
        sb.push_back(model(1'b0, 32'd3, 32'hFFFFFFFC));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op    = 1'b1;
        a     = 32'h00000005;
        b     = 32'h00000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        chk("ignored_done", 32'(done), 32'd0);
        chk("ignored_dz", 32'(div_zero), 32'd0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        last_hi = '0;
        last_lo = '0;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dz", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("no_done_after_abort", 32'(cnt), 32'd0);
        run_op(1'b0, 32'h00000003, 32'hFFFFFFFC, model(1'b0, 32'd3, 32'hFFFFFFFC), 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
